accum_writeback_ctrl: RTL and testbench
=======================================

Name: accum_writeback_ctrl

Overview:
Sequences the drain of finished result rows from the accumulator into the unified buffer. It issues accumulator reads, applies per-lane ReLU and requantisation (round, shift, saturate) to activation width, and writes the rows to consecutive unified-buffer addresses. It sits between accumulator data_o and the unified buffer write port, and is started by control_unit once a tile is complete. The UB write port is shared, so every write waits on a grant from the port arbiter.

Parameters:
ACC_RD_LAT, 1, accumulator read latency in cycles from addr_rd to data_o valid (1..3)
FIFO_DEPTH, ACC_RD_LAT+2, result skid FIFO depth in rows
(MUL_SIZE, ACT_WIDTH, RES_WIDTH come from tpu_package)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start pulse; sampled only in IDLE
rows_i  in  8  rows to drain; 0..128, values >128 clamp to 128
accum_base_i  in  7  first accumulator address
ub_base_i  in  12  first unified-buffer write address
shift_i  in  5  arithmetic right-shift amount
relu_en_i  in  1  clamp negatives to 0 before shifting
accum_data_i  in  MUL_SIZE x (RES_WIDTH+1)  accumulator read data
ub_grant_i  in  1  UB write port granted this cycle
accum_rd_en_o  out  1  accumulator read strobe
accum_addr_rd_o  out  7  accumulator read address
ub_wr_req_o  out  1  request for the UB write port
ub_wr_o  out  1  UB write strobe (ub_wr_req_o & ub_grant_i)
ub_addr_wr_o  out  12  UB write address
ub_data_o  out  MUL_SIZE x (ACT_WIDTH+1)  requantised row
busy_o  out  1  high from start acceptance until done
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, any state): every output is 0, state goes to IDLE, FIFO is flushed and counters are cleared. Reset mid-drain abandons the drain with no further writes.
- FSM: IDLE -> RUN on start_i. RUN -> DRAIN when issued == rows. DRAIN -> DONE when written == rows. DONE -> IDLE after 1 cycle, with done_o=1 and busy_o=0.
- On start, latch rows, bases, shift and relu_en. start_i while not IDLE is ignored.
- rows_i=0: the block passes IDLE->RUN->DRAIN->DONE with no reads or writes. done_o pulses in the 3rd cycle after start.
- Read issue in RUN: accum_rd_en_o=1 when (fifo_count + inflight) < FIFO_DEPTH. Address is accum_base + issued, mod 128. issued increments on each read.
- inflight counts reads issued whose data has not yet returned. Data returns exactly ACC_RD_LAT cycles after issue; a shift register of valid bits tracks this.
- Requantise stage (one register stage, lane-independent, signed):
  - v = (relu_en && x<0) ? 0 : x.
  - If shift>0: v = (v + 2^(shift-1)) >>> shift, computed with a RES_WIDTH+2 bit intermediate so it cannot overflow. If shift=0: v unchanged.
  - Saturate to [-2^ACT_WIDTH, 2^ACT_WIDTH-1].
  - The stage result is pushed into the FIFO. Credit accounting guarantees the push never meets a full FIFO.
- Write side: ub_wr_req_o = FIFO non-empty. ub_data_o = FIFO head. ub_addr_wr_o = ub_base + written, mod 4096 (wrap is legal).
  - When grant=1, the write occurs, the FIFO pops and written increments.
  - When grant=0, data and address hold stable.
- Reads and writes may occur in the same cycle. Throughput is 1 row/cycle under continuous grant.
- Latency with continuous grant: first ub_wr_o occurs at start + 1 + ACC_RD_LAT + 1 + 1 cycles.
- busy_o = (state != IDLE && state != DONE).

Decomposition:
- tpu_package gains:
  - typedef wb_state_t {IDLE, RUN, DRAIN, DONE}.
  - constants ACCUM_DEPTH=128 and UB_ADDR_W=12.
  - function requant(res, shift, relu), shared with future bench models.
- Sub-module wb_skid_fifo: synchronous FIFO, FIFO_DEPTH x MUL_SIZE lanes, with push/pop/count/empty and asynchronous reset.

Test Plan:
Bench config: MUL_SIZE=4, ACT_WIDTH=7, RES_WIDTH=31, ACC_RD_LAT=1.
- rows=4, accum_base=0, ub_base=0x010, shift=0, relu off, grant held 1, lanes = row index -> writes to 0x010..0x013 on 4 consecutive cycles with data 0,1,2,3. done_o pulses once, the cycle after the last write.
- Requant, single row, lanes {300, -300, 5, -6}, shift=2, relu off -> {75, -75, 1, -1} (5 rounds to (5+2)>>2 = 1; -6 rounds to (-6+2)>>>2 = -1). With shift=0 the same lanes saturate to {127, -128, 5, -6}. With relu on and shift=0 -> {127, 0, 5, 0}.
- Backpressure, rows=8, grant toggling 1,0,0,1,... -> the FIFO never overflows, accum_rd_en_o stalls once the credit limit is reached, all 8 rows are written in order, and address and data stay stable while grant=0.
- Wrap: ub_base=0xFFE, accum_base=126, rows=4 -> accumulator reads 126,127,0,1; UB writes 0xFFE,0xFFF,0x000,0x001.
- rows=0 -> no accum_rd_en_o, no ub_wr_o, and done_o high exactly 3 cycles after start. rows=200 -> exactly 128 writes.
- Assert rst_i mid-drain after 3 of 8 writes -> all outputs 0 asynchronously. After reset release, a new start of rows=2 writes cleanly with no residual rows. start_i pulsed while busy is ignored (write count unchanged).

Source files
------------

// File: rtl/tpu_package.sv
// Shared TPU datapath sizes plus the writeback-controller types and the
// requantisation helper used by the accumulator drain path.
package tpu_package;

    localparam int unsigned MUL_SIZE    = 4;
    localparam int unsigned ACT_WIDTH   = 7;
    localparam int unsigned RES_WIDTH   = 31;
    localparam int unsigned ACCUM_DEPTH = 128;
    localparam int unsigned UB_ADDR_W   = 12;
    localparam int unsigned ACC_ADDR_W  = $clog2(ACCUM_DEPTH);
    localparam int unsigned SHIFT_W     = 5;

    // Two bits above the accumulator width so rounding can never overflow.
    localparam int unsigned REQ_W = RES_WIDTH + 2;
    localparam logic signed [REQ_W-1:0] ACT_MAX = REQ_W'((2 ** ACT_WIDTH) - 1);
    localparam logic signed [REQ_W-1:0] ACT_MIN = REQ_W'(-(2 ** ACT_WIDTH));

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } wb_state_t;

    function automatic logic [ACT_WIDTH:0] requant(
        input logic signed [RES_WIDTH:0] res,
        input logic [SHIFT_W-1:0]        shift,
        input logic                      relu
    );
        logic signed [REQ_W-1:0] v;
        logic signed [REQ_W-1:0] rnd;
        v = (relu && (res < 0)) ? '0 : REQ_W'(res);
        if (shift != '0) begin
            rnd = REQ_W'(1) << (shift - SHIFT_W'(1));
            v   = (v + rnd) >>> shift;
        end
        if (v > ACT_MAX) begin
            v = ACT_MAX;
        end else if (v < ACT_MIN) begin
            v = ACT_MIN;
        end
        return v[ACT_WIDTH:0];
    endfunction

endpackage

// File: rtl/accum_writeback_ctrl_fifo.sv
// Skid FIFO holding requantised rows between the requant stage and the
// shared unified-buffer write port.
module wb_skid_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Depth need not be a power of two, so pointers wrap explicitly.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/accum_writeback_ctrl.sv
// Drains finished accumulator rows through ReLU/requantisation into
// consecutive unified-buffer addresses, arbitrating for the shared write port.
module accum_writeback_ctrl
    import tpu_package::*;
#(
    parameter int unsigned ACC_RD_LAT = 1,
    parameter int unsigned FIFO_DEPTH = ACC_RD_LAT + 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [7:0]                        rows_i,
    input  logic [ACC_ADDR_W-1:0]             accum_base_i,
    input  logic [UB_ADDR_W-1:0]              ub_base_i,
    input  logic [SHIFT_W-1:0]                shift_i,
    input  logic                              relu_en_i,
    input  logic [MUL_SIZE*(RES_WIDTH+1)-1:0] accum_data_i,
    input  logic                              ub_grant_i,
    output logic                              accum_rd_en_o,
    output logic [ACC_ADDR_W-1:0]             accum_addr_rd_o,
    output logic                              ub_wr_req_o,
    output logic                              ub_wr_o,
    output logic [UB_ADDR_W-1:0]              ub_addr_wr_o,
    output logic [MUL_SIZE*(ACT_WIDTH+1)-1:0] ub_data_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned ROW_W = MUL_SIZE * (ACT_WIDTH + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RES_L = RES_WIDTH + 1;
    localparam int unsigned ACT_L = ACT_WIDTH + 1;

    wb_state_t              state_q, state_d;
    logic [7:0]             rows_q, rows_d;
    logic [ACC_ADDR_W-1:0]  accum_base_q, accum_base_d;
    logic [UB_ADDR_W-1:0]   ub_base_q, ub_base_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic                   relu_q, relu_d;
    logic [7:0]             issued_q, issued_d;
    logic [7:0]             written_q, written_d;
    logic [ACC_RD_LAT-1:0]  vld_q, vld_d;
    logic                   rq_valid_q, rq_valid_d;
    logic [ROW_W-1:0]       rq_data_q, rq_data_d;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic [ROW_W-1:0]       fifo_head;
    logic [7:0]             vld_cnt;
    logic [7:0]             occupancy;
    logic                   rd_en;
    logic                   wr_req;
    logic                   wr_en;

    wb_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ROW_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rq_valid_q),
        .data_i  (rq_data_q),
        .pop_i   (wr_en),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // Credit check: every row in the read pipe, the requant register or the
    // FIFO holds a slot. A pop this cycle frees one, which is what lets the
    // drain sustain one row per cycle without ever pushing into a full FIFO.
    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < ACC_RD_LAT; i++) begin
            vld_cnt = vld_cnt + 8'(vld_q[i]);
        end
        occupancy = 8'(fifo_count) + vld_cnt + 8'(rq_valid_q);
        wr_req    = !fifo_empty;
        wr_en     = wr_req && ub_grant_i;
        rd_en     = (state_q == StRun) && (issued_q != rows_q) &&
                    ((occupancy - 8'(wr_en)) < 8'(FIFO_DEPTH));
    end

    always_comb begin
        vld_d      = ACC_RD_LAT'({vld_q, rd_en});
        rq_valid_d = vld_q[ACC_RD_LAT-1];
        rq_data_d  = '0;
        for (int l = 0; l < MUL_SIZE; l++) begin
            rq_data_d[l*ACT_L +: ACT_L] = requant(accum_data_i[l*RES_L +: RES_L], shift_q, relu_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        accum_base_d = accum_base_q;
        ub_base_d    = ub_base_q;
        shift_d      = shift_q;
        relu_d       = relu_q;
        issued_d     = issued_q + 8'(rd_en);
        written_d    = written_q + 8'(wr_en);
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    rows_d       = (rows_i > 8'(ACCUM_DEPTH)) ? 8'(ACCUM_DEPTH) : rows_i;
                    accum_base_d = accum_base_i;
                    ub_base_d    = ub_base_i;
                    shift_d      = shift_i;
                    relu_d       = relu_en_i;
                    issued_d     = '0;
                    written_d    = '0;
                    state_d      = StRun;
                end
            end
            StRun: begin
                if (issued_q == rows_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Look at the post-write count so done follows the last write directly.
                if (written_d == rows_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            rows_q       <= '0;
            accum_base_q <= '0;
            ub_base_q    <= '0;
            shift_q      <= '0;
            relu_q       <= 1'b0;
            issued_q     <= '0;
            written_q    <= '0;
            vld_q        <= '0;
            rq_valid_q   <= 1'b0;
            rq_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            accum_base_q <= accum_base_d;
            ub_base_q    <= ub_base_d;
            shift_q      <= shift_d;
            relu_q       <= relu_d;
            issued_q     <= issued_d;
            written_q    <= written_d;
            vld_q        <= vld_d;
            rq_valid_q   <= rq_valid_d;
            rq_data_q    <= rq_data_d;
        end
    end

    assign accum_rd_en_o   = rd_en;
    assign accum_addr_rd_o = accum_base_q + issued_q[ACC_ADDR_W-1:0];
    assign ub_wr_req_o     = wr_req;
    assign ub_wr_o         = wr_en;
    assign ub_addr_wr_o    = ub_base_q + UB_ADDR_W'(written_q);
    assign ub_data_o       = fifo_head;
    assign busy_o          = (state_q == StRun) || (state_q == StDrain);
    assign done_o          = (state_q == StDone);

endmodule

// File: tb/tb_accum_writeback_ctrl.sv
// Scoreboard bench: a driver queues expected reads/writes from a behavioural
// model, a negedge monitor checks everything the DUT presents.
module tb_accum_writeback_ctrl;

    localparam int DEPTH = 3;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [7:0]   rows_i = '0;
    logic [6:0]   accum_base_i = '0;
    logic [11:0]  ub_base_i = '0;
    logic [4:0]   shift_i = '0;
    logic         relu_en_i = 1'b0;
    logic [127:0] accum_data_i;
    logic         ub_grant_i = 1'b0;
    logic         accum_rd_en_o;
    logic [6:0]   accum_addr_rd_o;
    logic         ub_wr_req_o;
    logic         ub_wr_o;
    logic [11:0]  ub_addr_wr_o;
    logic [31:0]  ub_data_o;
    logic         busy_o;
    logic         done_o;

    accum_writeback_ctrl #(
        .ACC_RD_LAT (1)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .rows_i          (rows_i),
        .accum_base_i    (accum_base_i),
        .ub_base_i       (ub_base_i),
        .shift_i         (shift_i),
        .relu_en_i       (relu_en_i),
        .accum_data_i    (accum_data_i),
        .ub_grant_i      (ub_grant_i),
        .accum_rd_en_o   (accum_rd_en_o),
        .accum_addr_rd_o (accum_addr_rd_o),
        .ub_wr_req_o     (ub_wr_req_o),
        .ub_wr_o         (ub_wr_o),
        .ub_addr_wr_o    (ub_addr_wr_o),
        .ub_data_o       (ub_data_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          gmode = 0;
    int          done_cnt, done_cyc, first_wr, last_wr, wr_cnt, occ, sc;
    logic [127:0] acc_mem [128];
    logic [127:0] acc_rd_q = '0;
    logic [6:0]  rd_exp [$];
    wr_t         wr_exp [$];
    wr_t         e;
    logic        held_v = 1'b0;
    logic        held_g;
    logic [11:0] held_a;
    logic [31:0] held_d;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Accumulator memory with one cycle of read latency.
    always @(posedge clk) if (accum_rd_en_o) acc_rd_q <= acc_mem[accum_addr_rd_o];
    assign accum_data_i = acc_rd_q;

    initial forever begin
        @(posedge clk);
        #1;
        case (gmode)
            0:       ub_grant_i = 1'b1;
            1:       ub_grant_i = ((cyc % 3) == 0);
            default: ub_grant_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference requantisation written straight from the arithmetic rules.
    function automatic logic [7:0] ref_rq(input longint x, input int sh, input bit relu);
        longint v;
        v = (relu && x < 0) ? 0 : x;
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    always @(negedge clk) begin
        if (rst_i) begin
            held_v = 1'b0;
            occ = 0;
        end else begin
            if (accum_rd_en_o) begin
                if (rd_exp.size() == 0) chk("unexpected_read", 1, 0);
                else chk("read_addr", accum_addr_rd_o, rd_exp.pop_front());
            end
            occ = occ + int'(accum_rd_en_o) - int'(ub_wr_o);
            if (accum_rd_en_o) chk("credit_limit", (occ > DEPTH), 0);
            if (ub_wr_req_o) chk("wr_strobe", ub_wr_o, ub_grant_i);
            if (held_v && !held_g) begin
                chk("hold_req", ub_wr_req_o, 1);
                chk("hold_addr", ub_addr_wr_o, held_a);
                chk("hold_data", ub_data_o, held_d);
            end
            if (ub_wr_o) begin
                if (wr_exp.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    e = wr_exp.pop_front();
                    chk("wr_addr", ub_addr_wr_o, e.addr);
                    chk("wr_data", ub_data_o, e.data);
                end
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            held_v = ub_wr_req_o;
            held_g = ub_grant_i;
            held_a = ub_addr_wr_o;
            held_d = ub_data_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_in_done", busy_o, 0);
            end
        end
    end

    task automatic do_start(input int rows, input int abase, input int ubase, input int sh,
                            input bit relu);
        int n;
        logic [127:0] r;
        logic [31:0] d;
        logic signed [31:0] lane;
        n = (rows > 128) ? 128 : rows;
        for (int i = 0; i < n; i++) begin
            rd_exp.push_back(7'((abase + i) % 128));
            r = acc_mem[(abase + i) % 128];
            for (int l = 0; l < 4; l++) begin
                lane = r[l*32 +: 32];
                d[l*8 +: 8] = ref_rq(longint'(lane), sh, relu);
            end
            wr_exp.push_back('{addr: 12'((ubase + i) % 4096), data: d});
        end
        @(posedge clk);
        #1;
        rows_i = 8'(rows);
        accum_base_i = 7'(abase);
        ub_base_i = 12'(ubase);
        shift_i = 5'(sh);
        relu_en_i = relu;
        start_i = 1'b1;
        sc = cyc;
        done_cnt = 0;
        done_cyc = -1;
        first_wr = -1;
        last_wr = -1;
        wr_cnt = 0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
    endtask

    task automatic run_job(input int rows, input int abase, input int ubase, input int sh,
                           input bit relu, input int gm, input bit chk_lat, input bit dup);
        gmode = gm;
        do_start(rows, abase, ubase, sh, relu);
        if (dup) begin
            rows_i = 8'd5;
            start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        for (int t = 0; t < 3000 && done_cnt == 0; t++) @(posedge clk);
        chk("done_seen", (done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        chk("done_once", done_cnt, 1);
        chk("reads_left", rd_exp.size(), 0);
        chk("writes_left", wr_exp.size(), 0);
        if (rows == 0) chk("zero_rows_done_cyc", done_cyc, sc + 3);
        if (chk_lat && rows > 0) begin
            chk("first_wr_latency", first_wr, sc + 4);
            chk("done_after_last_wr", done_cyc, last_wr + 1);
        end
        if (dup) chk("dup_start_writes", wr_cnt, rows);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) acc_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) acc_mem[i] = {4{32'(i)}};
        #2;
        chk("rst_rd_en", accum_rd_en_o, 0);
        chk("rst_wr_req", ub_wr_req_o, 0);
        chk("rst_wr", ub_wr_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_addr", {ub_addr_wr_o, accum_addr_rd_o}, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_i = 1'b0;

        // Lanes equal to row index, contiguous writes from 0x010.
        run_job(4, 0, 'h010, 0, 1'b0, 0, 1'b1, 1'b0);

        // Requantisation corner values on a single row.
        acc_mem[10] = {-32'sd6, 32'sd5, -32'sd300, 32'sd300};
        run_job(1, 10, 'h040, 2, 1'b0, 0, 1'b1, 1'b0);
        run_job(1, 10, 'h041, 0, 1'b0, 0, 1'b1, 1'b0);
        run_job(1, 10, 'h042, 0, 1'b1, 0, 1'b1, 1'b0);

        // Backpressure with grant 1,0,0,1,...
        run_job(8, 20, 'h100, 3, 1'b1, 1, 1'b0, 1'b0);

        // Address wrap on both sides.
        run_job(4, 126, 'hFFE, 1, 1'b0, 0, 1'b1, 1'b0);

        // Empty job and over-range row count.
        run_job(0, 5, 'h300, 0, 1'b0, 0, 1'b1, 1'b0);
        run_job(200, 64, 'h400, 17, 1'b0, 0, 1'b1, 1'b0);

        // Reset in the middle of a drain.
        gmode = 0;
        do_start(8, 30, 'h200, 0, 1'b0);
        for (int t = 0; t < 100 && wr_cnt < 3; t++) @(posedge clk);
        chk("pre_reset_writes", (wr_cnt >= 3), 1);
        #3;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_rd_en", accum_rd_en_o, 0);
        chk("mid_rst_wr_req", ub_wr_req_o, 0);
        chk("mid_rst_wr", ub_wr_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_data", ub_data_o, 0);
        chk("mid_rst_addr", {ub_addr_wr_o, accum_addr_rd_o}, 0);
        rd_exp.delete();
        wr_exp.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_i = 1'b0;
        run_job(2, 40, 'h500, 0, 1'b0, 0, 1'b1, 1'b1);

        // Randomised jobs under random grant.
        for (int k = 0; k < 6; k++) begin
            run_job(int'($urandom_range(1, 20)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 2, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
